// File: rtl/aes_round_sched.sv
// aes_round_sched: sequences one AES block through an external, shared round datapath.
// Latency: rsp_valid is set by the (Nr+1)th edge after the accept edge, so the
//   accept edge is edge 1 of Nr+2. An illegal mode is answered at the accept edge itself.
// Backpressure: one job at a time. req_ready is high only in IDLE. A result is held
//   in DONE until rsp_ready. IDLE is re-entered for one cycle before the next accept.
//
// Ports
//   clk, reset_n          : clock and synchronous active-low reset
//   req_valid/req_ready   : job handshake with req_mode (00/01/10 = 128/192/256, 11 illegal),
//                           req_decrypt and the 128-bit req_data block
//   dp_state, dp_decrypt  : state word and direction presented to the round datapath
//   rk_sel, round_kind    : round-key index and round type (00 ARK, 01 full, 10 final)
//   dp_result             : combinational datapath answer for the presented step
//   rsp_valid/rsp_ready   : result handshake with rsp_data and rsp_error
//   busy                  : high whenever the scheduler is not in IDLE
module aes_round_sched #(
  parameter int NR_128 = 10,
  parameter int NR_192 = 12,
  parameter int NR_256 = 14
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [1:0]   req_mode,
  input  logic         req_decrypt,
  input  logic [127:0] req_data,
  output logic [127:0] dp_state,
  output logic         dp_decrypt,
  output logic [3:0]   rk_sel,
  output logic [1:0]   round_kind,
  input  logic [127:0] dp_result,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_data,
  output logic         rsp_error,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, INIT, ROUND, DONE} fsm_t;

  localparam logic [1:0] KIND_ARK   = 2'b00;
  localparam logic [1:0] KIND_FULL  = 2'b01;
  localparam logic [1:0] KIND_FINAL = 2'b10;

  localparam logic [3:0] NR128 = 4'(NR_128);
  localparam logic [3:0] NR192 = 4'(NR_192);
  localparam logic [3:0] NR256 = 4'(NR_256);

  fsm_t         fsm;
  logic [127:0] state_q;  // working block; also the response payload
  logic         dec_q;    // direction latched at accept
  logic [3:0]   nr_q;     // round count latched at accept
  logic [3:0]   cnt_q;    // ROUND step number, 1..nr_q; 0 in INIT

  logic [3:0]   req_nr;
  logic         req_legal;
  logic         accept;
  logic [3:0]   cnt_nxt;
  logic         last_round;

  always_comb begin
    req_nr = NR128;
    case (req_mode)
      2'b00:   req_nr = NR128;
      2'b01:   req_nr = NR192;
      2'b10:   req_nr = NR256;
      default: req_nr = NR128;  // illegal jobs never use it
    endcase
  end

  assign req_legal  = (req_mode != 2'b11);
  assign accept     = req_valid && req_ready;
  // Only evaluated while cnt_q < nr_q, so the increment cannot wrap.
  assign cnt_nxt    = cnt_q + 4'd1;
  assign last_round = (cnt_q == nr_q);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fsm        <= IDLE;
      state_q    <= '0;
      dec_q      <= 1'b0;
      nr_q       <= '0;
      cnt_q      <= '0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_error  <= 1'b0;
      busy       <= 1'b0;
      rk_sel     <= '0;
      round_kind <= KIND_ARK;
    end else begin
      case (fsm)
        IDLE: begin
          if (accept) begin
            state_q   <= req_data;
            dec_q     <= req_decrypt;
            nr_q      <= req_nr;
            cnt_q     <= '0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (req_legal) begin
              fsm        <= INIT;
              // Initial AddRoundKey uses key 0 forward, key Nr inverse.
              rk_sel     <= req_decrypt ? req_nr : 4'd0;
              round_kind <= KIND_ARK;
            end else begin
              // The block is echoed back untouched with the error flag.
              fsm       <= DONE;
              rsp_valid <= 1'b1;
              rsp_error <= 1'b1;
            end
          end
        end

        INIT, ROUND: begin
          state_q <= dp_result;
          if (fsm == ROUND && last_round) begin
            fsm        <= DONE;
            rsp_valid  <= 1'b1;
            rk_sel     <= '0;
            round_kind <= KIND_ARK;
          end else begin
            // Set up step cnt_nxt: key index walks up (forward) or down (inverse).
            fsm        <= ROUND;
            cnt_q      <= cnt_nxt;
            rk_sel     <= dec_q ? (nr_q - cnt_nxt) : cnt_nxt;
            round_kind <= (cnt_nxt == nr_q) ? KIND_FINAL : KIND_FULL;
          end
        end

        DONE: begin
          // Return through IDLE so a new job is never taken on the response edge.
          if (rsp_ready) begin
            fsm       <= IDLE;
            rsp_valid <= 1'b0;
            rsp_error <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end
        end

        default: fsm <= IDLE;
      endcase
    end
  end

  assign dp_state   = state_q;
  assign dp_decrypt = dec_q;
  assign rsp_data   = state_q;

  a_rk_range: assert property (@(posedge clk) disable iff (!reset_n) rk_sel <= nr_q);
  a_ready_idle: assert property (@(posedge clk) disable iff (!reset_n) req_ready == (fsm == IDLE));
  a_busy: assert property (@(posedge clk) disable iff (!reset_n) busy == (fsm != IDLE));
  a_rsp_hold: assert property (@(posedge clk) disable iff (!reset_n)
                               rsp_valid && !rsp_ready |=> rsp_valid && $stable(rsp_data));

endmodule
